opr3_eae_seq: RTL and testbench

- Sequenced execution unit for PDP-8 group-3 operate instructions (CLA/MQA/SCA/MQL) plus the EAE step codes SCL, NMI, SHL, ASR and LSR.
- Owns the MQ and SC registers and has its own step state machine, so it no longer depends on externally supplied ck/stb phase strobes.
- Data width is parametrised.
- Sits beside the AC/link datapath: takes AC/link at start and returns AC/link with a one-cycle write strobe at completion.

---
 rtl/opr3_pkg.sv | 38 +++
 rtl/opr3_eae_seq_if.sv | 33 +++
 rtl/opr3_shifter.sv | 47 ++++
 rtl/opr3_eae_seq.sv | 161 ++++++++++++++++
 tb/tb_opr3_eae_seq.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/opr3_pkg.sv
// Shared types for the PDP-8 group-3 operate / EAE sequencer.
package opr3_pkg;

   typedef enum logic [2:0] {
      EAE_NOP = 3'd0,
      EAE_SCL = 3'd1,
      EAE_MUY = 3'd2,
      EAE_DVI = 3'd3,
      EAE_NMI = 3'd4,
      EAE_SHL = 3'd5,
      EAE_ASR = 3'd6,
      EAE_LSR = 3'd7
   } eae_code_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOGIC = 3'd1,
      ST_SHIFT = 3'd2,
      ST_NORM  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      SH_SHL  = 2'd0,
      SH_ASR  = 2'd1,
      SH_LSR  = 2'd2,
      SH_NORM = 2'd3
   } shift_mode_e;

   // MUY and DVI complete after the logic step with illegal asserted.
   localparam eae_code_e ILLEGAL_CODE_A = EAE_MUY;
   localparam eae_code_e ILLEGAL_CODE_B = EAE_DVI;

   function automatic logic is_illegal(eae_code_e code);
      return (code == ILLEGAL_CODE_A) || (code == ILLEGAL_CODE_B);
   endfunction

endpackage

// File: rtl/opr3_eae_seq_if.sv
// Request/result bundle between the AC datapath and the operate/EAE sequencer.
interface opr3_eae_seq_if #(
   parameter int unsigned WIDTH    = 12,
   parameter int unsigned SC_WIDTH = 5
);
   logic                start;
   logic                opr_cla;
   logic                opr_mqa;
   logic                opr_sca;
   logic                opr_mql;
   logic [2:0]          eae_code;
   logic [WIDTH-1:0]    operand;
   logic [WIDTH-1:0]    ac_in;
   logic                link_in;
   logic [WIDTH-1:0]    ac_out;
   logic                link_out;
   logic                ac_we;
   logic [WIDTH-1:0]    mq;
   logic [SC_WIDTH-1:0] sc;
   logic                busy;
   logic                done;
   logic                illegal;

   modport master (
      output start, opr_cla, opr_mqa, opr_sca, opr_mql, eae_code, operand, ac_in, link_in,
      input  ac_out, link_out, ac_we, mq, sc, busy, done, illegal
   );

   modport slave (
      input  start, opr_cla, opr_mqa, opr_sca, opr_mql, eae_code, operand, ac_in, link_in,
      output ac_out, link_out, ac_we, mq, sc, busy, done, illegal
   );
endinterface

// File: rtl/opr3_shifter.sv
// Combinational one-bit shift of {link,ac,mq}; NORM shifts left like SHL.
module opr3_shifter
   import opr3_pkg::*;
#(
   parameter int unsigned WIDTH = 12
) (
   input  shift_mode_e      mode,
   input  logic             link,
   input  logic [WIDTH-1:0] ac,
   input  logic [WIDTH-1:0] mq,
   output logic             link_c,
   output logic [WIDTH-1:0] ac_c,
   output logic [WIDTH-1:0] mq_c
);
   localparam int unsigned DW = 2 * WIDTH;

   logic [DW-1:0] word;
   logic [DW-1:0] res;

   assign word = {ac, mq};

   always_comb begin
      res    = word;
      link_c = link;
      case (mode)
         SH_SHL, SH_NORM: begin
            res    = {word[DW-2:0], 1'b0};
            link_c = word[DW-1];
         end
         SH_ASR: begin
            res    = {word[DW-1], word[DW-1:1]};
            link_c = word[DW-1];
         end
         SH_LSR: begin
            res    = {1'b0, word[DW-1:1]};
            link_c = 1'b0;
         end
         default: begin
            res    = word;
            link_c = link;
         end
      endcase
   end

   assign {ac_c, mq_c} = res;

endmodule

// File: rtl/opr3_eae_seq.sv
// Sequenced group-3 operate / EAE step unit owning MQ and SC.
module opr3_eae_seq
   import opr3_pkg::*;
#(
   parameter int unsigned WIDTH    = 12,
   parameter int unsigned SC_WIDTH = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   opr3_eae_seq_if.slave   bus
);
   state_e              state;
   eae_code_e           code;
   logic                cla, mqa, sca, mql;
   logic [SC_WIDTH-1:0] cnt;
   logic [SC_WIDTH-1:0] sc_r;
   logic [WIDTH-1:0]    ac_r, mq_r, ac_out;
   logic                link_r, link_out;
   logic                ac_we, done, busy, illegal;

   logic [WIDTH-1:0]    a1, logic_ac;
   shift_mode_e         mode;
   logic                sh_link;
   logic [WIDTH-1:0]    sh_ac, sh_mq;
   logic                norm_stop;

   // SCA sees the SC value from before this instruction touches it.
   assign a1       = cla ? '0 : ac_r;
   assign logic_ac = (mqa ? mq_r : '0) | (sca ? WIDTH'(sc_r) : '0) | (mql ? '0 : a1);

   always_comb begin
      mode = SH_NORM;
      case (code)
         EAE_SHL: mode = SH_SHL;
         EAE_ASR: mode = SH_ASR;
         EAE_LSR: mode = SH_LSR;
         default: mode = SH_NORM;
      endcase
   end

   // Saturated SC also ends normalisation so the count never wraps.
   assign norm_stop = (ac_r[WIDTH-1] != ac_r[WIDTH-2]) || ({ac_r, mq_r} == '0) || (sc_r == '1);

   opr3_shifter #(.WIDTH(WIDTH)) u_shifter (
      .mode   (mode),
      .link   (link_r),
      .ac     (ac_r),
      .mq     (mq_r),
      .link_c (sh_link),
      .ac_c   (sh_ac),
      .mq_c   (sh_mq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         code     <= EAE_NOP;
         cla      <= 1'b0;
         mqa      <= 1'b0;
         sca      <= 1'b0;
         mql      <= 1'b0;
         cnt      <= '0;
         sc_r     <= '0;
         ac_r     <= '0;
         mq_r     <= '0;
         link_r   <= 1'b0;
         ac_out   <= '0;
         link_out <= 1'b0;
         ac_we    <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         ac_we   <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  ac_r   <= bus.ac_in;
                  link_r <= bus.link_in;
                  cla    <= bus.opr_cla;
                  mqa    <= bus.opr_mqa;
                  sca    <= bus.opr_sca;
                  mql    <= bus.opr_mql;
                  code   <= eae_code_e'(bus.eae_code);
                  cnt    <= bus.operand[SC_WIDTH-1:0];
                  busy   <= 1'b1;
                  state  <= ST_LOGIC;
               end
            end
            ST_LOGIC: begin
               ac_r <= logic_ac;
               if (mql) mq_r <= a1;
               case (code)
                  EAE_SHL, EAE_ASR, EAE_LSR: begin
                     sc_r  <= cnt;
                     state <= ST_SHIFT;
                  end
                  EAE_NMI: begin
                     sc_r  <= '0;
                     state <= ST_NORM;
                  end
                  default: begin
                     if (code == EAE_SCL) sc_r <= cnt;
                     ac_out   <= logic_ac;
                     link_out <= link_r;
                     ac_we    <= 1'b1;
                     done     <= 1'b1;
                     illegal  <= is_illegal(code);
                     state    <= ST_DONE;
                  end
               endcase
            end
            ST_SHIFT: begin
               ac_r   <= sh_ac;
               mq_r   <= sh_mq;
               link_r <= sh_link;
               if (sc_r == '0) begin
                  ac_out   <= sh_ac;
                  link_out <= sh_link;
                  ac_we    <= 1'b1;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  sc_r <= sc_r - SC_WIDTH'(1);
               end
            end
            ST_NORM: begin
               if (norm_stop) begin
                  ac_out   <= ac_r;
                  link_out <= link_r;
                  ac_we    <= 1'b1;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  ac_r   <= sh_ac;
                  mq_r   <= sh_mq;
                  link_r <= sh_link;
                  sc_r   <= sc_r + SC_WIDTH'(1);
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ac_out   = ac_out;
   assign bus.link_out = link_out;
   assign bus.ac_we    = ac_we;
   assign bus.mq       = mq_r;
   assign bus.sc       = sc_r;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.illegal  = illegal;

endmodule

// File: tb/tb_opr3_eae_seq.sv
// Randomised bench for opr3_eae_seq against an arithmetic reference model.
module tb_opr3_eae_seq;
   localparam int unsigned WIDTH    = 12;
   localparam int unsigned SC_WIDTH = 5;
   localparam int unsigned DW       = 2 * WIDTH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   opr3_eae_seq_if #(.WIDTH(WIDTH), .SC_WIDTH(SC_WIDTH)) bus ();

   opr3_eae_seq #(.WIDTH(WIDTH), .SC_WIDTH(SC_WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference architectural state
   logic [WIDTH-1:0]    m_ac_out;
   logic                m_link_out;
   logic [WIDTH-1:0]    m_mq;
   logic [SC_WIDTH-1:0] m_sc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0o expected %0o (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic run_op(input bit cla, input bit mqa, input bit sca, input bit mql,
                         input int code, input logic [WIDTH-1:0] opnd,
                         input logic [WIDTH-1:0] ac_in, input bit link_in, input bit poke);
      logic [WIDTH-1:0] a1, ac;
      logic [DW-1:0]    v;
      logic [DW-1:0]    top;
      logic             lk;
      int               lat, n, cyc;
      bit               ill, seen;

      top = '0;
      top[DW-1] = 1'b1;
      a1 = cla ? '0 : ac_in;
      ac = (mqa ? m_mq : '0) | (sca ? WIDTH'(m_sc) : '0) | (mql ? '0 : a1);
      if (mql) m_mq = a1;
      lk  = link_in;
      lat = 2;
      ill = (code == 2) || (code == 3);
      v   = {ac, m_mq};
      n   = int'(opnd % (2 ** SC_WIDTH));
      if (code == 1) begin
         m_sc = SC_WIDTH'(n);
      end else if (code >= 5) begin
         for (int i = 0; i <= n; i++) begin
            if (code == 5) begin
               lk = (v & top) != '0;
               v  = v << 1;
            end else if (code == 6) begin
               lk = (v & top) != '0;
               v  = (v >> 1) | (v & top);
            end else begin
               lk = 1'b0;
               v  = v >> 1;
            end
         end
         m_sc = '0;
         lat  = 3 + n;
      end else if (code == 4) begin
         m_sc = '0;
         cyc  = 0;
         while (v != '0 && (((v >> (DW - 1)) & 1) == ((v >> (DW - 2)) & 1)) && m_sc != '1) begin
            lk = (v & top) != '0;
            v  = v << 1;
            m_sc++;
            cyc++;
         end
         lat = 3 + cyc;
      end
      m_ac_out   = WIDTH'(v >> WIDTH);
      m_mq       = WIDTH'(v);
      m_link_out = lk;

      @(negedge clk);
      bus.start    = 1'b1;
      bus.opr_cla  = cla;
      bus.opr_mqa  = mqa;
      bus.opr_sca  = sca;
      bus.opr_mql  = mql;
      bus.eae_code = 3'(code);
      bus.operand  = opnd;
      bus.ac_in    = ac_in;
      bus.link_in  = link_in;
      @(posedge clk); #1;
      check("busy_after_start", 32'(bus.busy), 32'd1);
      if (poke) begin
         bus.ac_in    = WIDTH'($urandom);
         bus.eae_code = 3'($urandom);
         bus.opr_mql  = ~mql;
         bus.operand  = WIDTH'($urandom);
      end else begin
         bus.start = 1'b0;
      end
      cyc  = 1;
      seen = 1'b0;
      while (cyc < 200 && !seen) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 2) bus.start = 1'b0;
         seen = bus.done;
      end
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         check("latency",  32'(cyc),           32'(lat));
         check("ac_out",   32'(bus.ac_out),    32'(m_ac_out));
         check("link_out", 32'(bus.link_out),  32'(m_link_out));
         check("mq",       32'(bus.mq),        32'(m_mq));
         check("sc",       32'(bus.sc),        32'(m_sc));
         check("ac_we",    32'(bus.ac_we),     32'd1);
         check("illegal",  32'(bus.illegal),   32'(ill));
         check("busy_done", 32'(bus.busy),     32'd1);
      end
      @(posedge clk); #1;
      check("ac_we_one_cycle", 32'(bus.ac_we), 32'd0);
      check("done_one_cycle",  32'(bus.done),  32'd0);
      check("busy_clear",      32'(bus.busy),  32'd0);
      check("ac_out_hold",     32'(bus.ac_out), 32'(m_ac_out));
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.opr_cla  = 1'b0;
      bus.opr_mqa  = 1'b0;
      bus.opr_sca  = 1'b0;
      bus.opr_mql  = 1'b0;
      bus.eae_code = 3'd0;
      bus.operand  = '0;
      bus.ac_in    = '0;
      bus.link_in  = 1'b0;
      m_ac_out     = '0;
      m_link_out   = 1'b0;
      m_mq         = '0;
      m_sc         = '0;

      repeat (3) @(negedge clk);
      check("rst_ac_out", 32'(bus.ac_out), 32'd0);
      check("rst_mq",     32'(bus.mq),     32'd0);
      check("rst_sc",     32'(bus.sc),     32'd0);
      check("rst_busy",   32'(bus.busy),   32'd0);
      check("rst_ac_we",  32'(bus.ac_we),  32'd0);
      rst_n = 1'b1;

      // MQ preset, then SWP
      run_op(0, 0, 0, 1, 0, '0, 12'o5670, 0, 0);
      run_op(0, 1, 0, 1, 0, '0, 12'o1234, 0, 0);
      // CLA,SWP after loading MQ and clearing SC
      run_op(0, 0, 0, 1, 1, 12'o0000, 12'o4321, 0, 0);
      run_op(1, 1, 0, 1, 0, '0, 12'o7777, 1, 0);
      // SCL then SCA
      run_op(0, 0, 0, 0, 1, 12'o0007, 12'o0000, 0, 0);
      run_op(0, 0, 1, 0, 0, '0, 12'o0010, 0, 0);
      // Shifts: preload MQ=4000 then SHL by 2+1
      run_op(0, 0, 0, 1, 0, '0, 12'o4000, 0, 0);
      run_op(0, 0, 0, 0, 5, 12'o0002, 12'o0001, 1, 0);
      run_op(1, 0, 0, 1, 0, '0, 12'o0000, 0, 0);
      run_op(0, 0, 0, 0, 6, 12'o0001, 12'o4000, 0, 0);
      run_op(1, 0, 0, 1, 0, '0, 12'o0000, 0, 0);
      run_op(0, 0, 0, 0, 7, 12'o0001, 12'o4000, 1, 0);
      run_op(0, 0, 0, 0, 7, 12'o0037, 12'o7777, 1, 0);
      // NMI: non-zero and all-zero
      run_op(1, 0, 0, 1, 0, '0, 12'o0000, 0, 0);
      run_op(0, 0, 0, 0, 4, '0, 12'o0001, 0, 0);
      run_op(1, 0, 0, 1, 0, '0, 12'o0000, 0, 0);
      run_op(0, 0, 0, 0, 4, '0, 12'o0000, 0, 0);
      // Illegal code with logic ops and a start poked while busy
      run_op(0, 1, 0, 1, 3, 12'o0005, 12'o0707, 1, 1);
      run_op(0, 0, 0, 0, 2, 12'o0003, 12'o1111, 0, 0);

      for (int i = 0; i < 80; i++) begin
         run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom),
                1'($urandom), ($urandom_range(0, 3) == 0));
      end

      // Reset while shifting
      @(negedge clk);
      bus.start    = 1'b1;
      bus.opr_cla  = 1'b0;
      bus.opr_mqa  = 1'b0;
      bus.opr_sca  = 1'b0;
      bus.opr_mql  = 1'b0;
      bus.eae_code = 3'd5;
      bus.operand  = 12'o0024;
      bus.ac_in    = 12'o0123;
      bus.link_in  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("mid_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_ac_out", 32'(bus.ac_out),   32'd0);
      check("abort_link",   32'(bus.link_out), 32'd0);
      check("abort_mq",     32'(bus.mq),       32'd0);
      check("abort_sc",     32'(bus.sc),       32'd0);
      check("abort_busy",   32'(bus.busy),     32'd0);
      check("abort_ac_we",  32'(bus.ac_we),    32'd0);
      check("abort_done",   32'(bus.done),     32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("abort_ac_we_hold", 32'(bus.ac_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_ac_out   = '0;
      m_link_out = 1'b0;
      m_mq       = '0;
      m_sc       = '0;
      repeat (3) @(posedge clk);
      #1;
      check("post_abort_ac_we", 32'(bus.ac_we), 32'd0);
      run_op(0, 1, 1, 1, 1, 12'o0003, 12'o2525, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
